// File: rtl/raw_waw_scoreboard_pkg.sv
// Shared types for the busy-register scoreboard: unit tags and register index width.
package sb_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    UNIT_MUL  = 2'd0,
    UNIT_DIV  = 2'd1,
    UNIT_FPU  = 2'd2,
    UNIT_FDIV = 2'd3
  } unit_tag_t;

endpackage

// File: rtl/raw_waw_scoreboard_if.sv
// ID/WB/status bundle of the scoreboard. SCOREBOARD_PERF_CNT_EN adds the stall counters.
interface raw_waw_scoreboard_if
  import sb_pkg::*;
#(
  parameter int n_regs = 32,
  parameter int PERF_W = 16
);

  logic                 stall_id;
  logic                 issue_valid_id;
  logic [REG_IDX_W-1:0] issue_rd_id;
  unit_tag_t            issue_unit_id;
  logic [REG_IDX_W-1:0] rs1_id;
  logic [REG_IDX_W-1:0] rs2_id;
  logic [REG_IDX_W-1:0] rs3_id;
  logic [2:0]           rs_used_id;
  logic                 rd_used_id;
  logic [REG_IDX_W-1:0] rd_id;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  unit_tag_t            wb_unit;
  logic                 busy_rs1;
  logic                 busy_rs2;
  logic                 busy_rs3;
  logic                 rd_not_busy;
  logic                 raw_stall;
  logic                 waw_stall;
  logic [n_regs-1:0]    busy_vec;
  logic                 sb_err;
`ifdef SCOREBOARD_PERF_CNT_EN
  logic [PERF_W-1:0]    raw_stall_cnt;
  logic [PERF_W-1:0]    waw_stall_cnt;

  modport master (
    output stall_id, issue_valid_id, issue_rd_id, issue_unit_id,
           rs1_id, rs2_id, rs3_id, rs_used_id, rd_used_id, rd_id,
           wb_valid, wb_rd, wb_unit,
    input  busy_rs1, busy_rs2, busy_rs3, rd_not_busy, raw_stall, waw_stall,
           busy_vec, sb_err, raw_stall_cnt, waw_stall_cnt
  );

  modport slave (
    input  stall_id, issue_valid_id, issue_rd_id, issue_unit_id,
           rs1_id, rs2_id, rs3_id, rs_used_id, rd_used_id, rd_id,
           wb_valid, wb_rd, wb_unit,
    output busy_rs1, busy_rs2, busy_rs3, rd_not_busy, raw_stall, waw_stall,
           busy_vec, sb_err, raw_stall_cnt, waw_stall_cnt
  );
`else
  modport master (
    output stall_id, issue_valid_id, issue_rd_id, issue_unit_id,
           rs1_id, rs2_id, rs3_id, rs_used_id, rd_used_id, rd_id,
           wb_valid, wb_rd, wb_unit,
    input  busy_rs1, busy_rs2, busy_rs3, rd_not_busy, raw_stall, waw_stall,
           busy_vec, sb_err
  );

  modport slave (
    input  stall_id, issue_valid_id, issue_rd_id, issue_unit_id,
           rs1_id, rs2_id, rs3_id, rs_used_id, rd_used_id, rd_id,
           wb_valid, wb_rd, wb_unit,
    output busy_rs1, busy_rs2, busy_rs3, rd_not_busy, raw_stall, waw_stall,
           busy_vec, sb_err
  );
`endif

endinterface

// File: rtl/raw_waw_scoreboard_entry.sv
// One scoreboard slot: busy bit plus owning-unit tag; a new issue beats a same-cycle clear.
module sb_entry
  import sb_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      set,
  input  logic      clr,
  input  unit_tag_t set_tag,
  output logic      busy_r,
  output unit_tag_t tag_r
);

  // busy/tag register with set-over-clear priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      tag_r  <= UNIT_MUL;
    end else if (set) begin
      busy_r <= 1'b1;
      tag_r  <= set_tag;
    end else if (clr) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

endmodule

// File: rtl/raw_waw_scoreboard.sv
// RAW/WAW busy-register scoreboard for multi-cycle units, with WB bypass of the busy bits.
// Optional stall counters under SCOREBOARD_PERF_CNT_EN.
module raw_waw_scoreboard
  import sb_pkg::*;
#(
  parameter int n_regs  = 32,
  parameter bit FP_type = 1'b0,
  parameter int PERF_W  = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  raw_waw_scoreboard_if.slave  sb
);

  logic [n_regs-1:0] busy_s;
  unit_tag_t         tag_s [n_regs];
  logic              clr_hit_s;
  logic              accept_s;
  logic              sb_err_r;

  assign clr_hit_s = sb.wb_valid & busy_s[sb.wb_rd] & (tag_s[sb.wb_rd] == sb.wb_unit);

  // A same-cycle matching writeback frees the register for the ID instruction.
  assign sb.busy_rs1 = sb.rs_used_id[0] & busy_s[sb.rs1_id] & ~(clr_hit_s & (sb.wb_rd == sb.rs1_id));
  assign sb.busy_rs2 = sb.rs_used_id[1] & busy_s[sb.rs2_id] & ~(clr_hit_s & (sb.wb_rd == sb.rs2_id));
  assign sb.busy_rs3 = sb.rs_used_id[2] & busy_s[sb.rs3_id] & ~(clr_hit_s & (sb.wb_rd == sb.rs3_id));
  assign sb.rd_not_busy = ~busy_s[sb.rd_id] | (clr_hit_s & (sb.wb_rd == sb.rd_id));
  assign sb.raw_stall   = sb.busy_rs1 | sb.busy_rs2 | sb.busy_rs3;
  assign sb.waw_stall   = sb.rd_used_id & ~sb.rd_not_busy;
  assign accept_s       = sb.issue_valid_id & ~sb.stall_id & ~sb.raw_stall & ~sb.waw_stall;
  assign sb.busy_vec    = busy_s;
  assign sb.sb_err      = sb_err_r;

  for (genvar i = 0; i < n_regs; i++) begin : g_entry
    if ((i == 0) && (FP_type == 1'b0)) begin : g_tie
      assign busy_s[i] = 1'b0;
      assign tag_s[i]  = UNIT_MUL;
    end else begin : g_slot
      logic set_s;
      logic clr_s;
      assign set_s = accept_s & (sb.issue_rd_id == REG_IDX_W'(i));
      assign clr_s = clr_hit_s & (sb.wb_rd == REG_IDX_W'(i));
      sb_entry u_entry (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (set_s),
        .clr     (clr_s),
        .set_tag (sb.issue_unit_id),
        .busy_r  (busy_s[i]),
        .tag_r   (tag_s[i])
      );
    end
  end

  // sticky error: writeback that matched no outstanding op of that unit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_err_r <= 1'b0;
    end else if (sb.wb_valid & ~clr_hit_s) begin
      sb_err_r <= 1'b1;
    end else begin
      sb_err_r <= sb_err_r;
    end
  end

`ifdef SCOREBOARD_PERF_CNT_EN
  logic [PERF_W-1:0] raw_cnt_r;
  logic [PERF_W-1:0] waw_cnt_r;

  assign sb.raw_stall_cnt = raw_cnt_r;
  assign sb.waw_stall_cnt = waw_cnt_r;

  // saturating stall counters, only for stalls this block causes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_cnt_r <= {PERF_W{1'b0}};
      waw_cnt_r <= {PERF_W{1'b0}};
    end else begin
      if (sb.raw_stall & ~sb.stall_id & (raw_cnt_r != {PERF_W{1'b1}})) begin
        raw_cnt_r <= raw_cnt_r + PERF_W'(1);
      end else begin
        raw_cnt_r <= raw_cnt_r;
      end
      if (sb.waw_stall & ~sb.stall_id & (waw_cnt_r != {PERF_W{1'b1}})) begin
        waw_cnt_r <= waw_cnt_r + PERF_W'(1);
      end else begin
        waw_cnt_r <= waw_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_raw_waw_scoreboard.sv
// Scoreboard bench: a reference model pushes expected outputs per driven cycle,
// popped and compared at the falling edge. Integer and FP instances are exercised.
module tb_raw_waw_scoreboard;
  import sb_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  raw_waw_scoreboard_if #(.n_regs(32), .PERF_W(4)) sbi ();
  raw_waw_scoreboard_if #(.n_regs(32), .PERF_W(4)) sbf ();

  raw_waw_scoreboard #(.n_regs(32), .FP_type(1'b0), .PERF_W(4)) u_dut_int (
    .clk(clk), .reset_n(reset_n), .sb(sbi)
  );
  raw_waw_scoreboard #(.n_regs(32), .FP_type(1'b1), .PERF_W(4)) u_dut_fp (
    .clk(clk), .reset_n(reset_n), .sb(sbf)
  );

  typedef struct {
    logic        b1, b2, b3, rnb, raw, waw, err;
    logic [31:0] bv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_busy;
  unit_tag_t   m_tag [32];
  logic        m_err;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 32'd0;
    m_err  = 1'b0;
    for (int i = 0; i < 32; i++) m_tag[i] = UNIT_MUL;
  endtask

  task automatic idle_if();
    sbi.stall_id = 1'b0; sbi.issue_valid_id = 1'b0; sbi.issue_rd_id = 5'd0; sbi.issue_unit_id = UNIT_MUL;
    sbi.rs1_id = 5'd0; sbi.rs2_id = 5'd0; sbi.rs3_id = 5'd0; sbi.rs_used_id = 3'd0;
    sbi.rd_used_id = 1'b0; sbi.rd_id = 5'd0; sbi.wb_valid = 1'b0; sbi.wb_rd = 5'd0; sbi.wb_unit = UNIT_MUL;
    sbf.stall_id = 1'b0; sbf.issue_valid_id = 1'b0; sbf.issue_rd_id = 5'd0; sbf.issue_unit_id = UNIT_MUL;
    sbf.rs1_id = 5'd0; sbf.rs2_id = 5'd0; sbf.rs3_id = 5'd0; sbf.rs_used_id = 3'd0;
    sbf.rd_used_id = 1'b0; sbf.rd_id = 5'd0; sbf.wb_valid = 1'b0; sbf.wb_rd = 5'd0; sbf.wb_unit = UNIT_MUL;
  endtask

  // One cycle on the integer instance: predict, push, compare at negedge, advance model.
  task automatic step();
    exp_t e, g;
    logic clr, acc;
    clr = sbi.wb_valid && m_busy[sbi.wb_rd] && (m_tag[sbi.wb_rd] == sbi.wb_unit);
    e.b1  = sbi.rs_used_id[0] && m_busy[sbi.rs1_id] && !(clr && (sbi.wb_rd == sbi.rs1_id));
    e.b2  = sbi.rs_used_id[1] && m_busy[sbi.rs2_id] && !(clr && (sbi.wb_rd == sbi.rs2_id));
    e.b3  = sbi.rs_used_id[2] && m_busy[sbi.rs3_id] && !(clr && (sbi.wb_rd == sbi.rs3_id));
    e.rnb = !m_busy[sbi.rd_id] || (clr && (sbi.wb_rd == sbi.rd_id));
    e.raw = e.b1 || e.b2 || e.b3;
    e.waw = sbi.rd_used_id && !e.rnb;
    e.bv  = m_busy;
    e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check_val("busy_rs1", {31'd0, sbi.busy_rs1}, {31'd0, g.b1});
    check_val("busy_rs2", {31'd0, sbi.busy_rs2}, {31'd0, g.b2});
    check_val("busy_rs3", {31'd0, sbi.busy_rs3}, {31'd0, g.b3});
    check_val("rd_not_busy", {31'd0, sbi.rd_not_busy}, {31'd0, g.rnb});
    check_val("raw_stall", {31'd0, sbi.raw_stall}, {31'd0, g.raw});
    check_val("waw_stall", {31'd0, sbi.waw_stall}, {31'd0, g.waw});
    check_val("busy_vec", sbi.busy_vec, g.bv);
    check_val("sb_err", {31'd0, sbi.sb_err}, {31'd0, g.err});
    @(posedge clk);
    acc = sbi.issue_valid_id && !sbi.stall_id && !g.raw && !g.waw;
    if (clr) m_busy[sbi.wb_rd] = 1'b0;
    if (acc && (sbi.issue_rd_id != 5'd0)) begin
      m_busy[sbi.issue_rd_id] = 1'b1;
      m_tag[sbi.issue_rd_id]  = sbi.issue_unit_id;
    end
    if (sbi.wb_valid && !clr) m_err = 1'b1;
    #1;
  endtask

  task automatic drive(input bit iv, input int ird, input unit_tag_t iu,
                       input int r1, input logic [2:0] rsu, input bit rdu, input int rd,
                       input bit wv, input int wrd, input unit_tag_t wu);
    sbi.issue_valid_id = iv; sbi.issue_rd_id = 5'(ird); sbi.issue_unit_id = iu;
    sbi.rs1_id = 5'(r1); sbi.rs2_id = 5'(r1 + 1); sbi.rs3_id = 5'(r1 + 2); sbi.rs_used_id = rsu;
    sbi.rd_used_id = rdu; sbi.rd_id = 5'(rd);
    sbi.wb_valid = wv; sbi.wb_rd = 5'(wrd); sbi.wb_unit = wu;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_if();
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    check_val("fp_busy_vec_reset", sbf.busy_vec, 32'd0);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 0, 0, UNIT_MUL);

    // MUL to x5, RAW, bypassed writeback
    drive(1, 5, UNIT_MUL, 0, 3'b000, 1, 5, 0, 0, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 5, 3'b001, 0, 0, 0, 0, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 5, 3'b001, 0, 0, 1, 5, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 0, 0, UNIT_MUL);

    // DIV to x7, WAW until writeback
    drive(1, 7, UNIT_DIV, 0, 3'b000, 1, 7, 0, 0, UNIT_MUL);
    repeat (3) drive(1, 7, UNIT_MUL, 0, 3'b000, 1, 7, 0, 0, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 1, 7, 1, 7, UNIT_DIV);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 0, 0, UNIT_MUL);

    // x9: FPU writeback and FDIV reissue in the same cycle; set wins, new tag retires it
    drive(1, 9, UNIT_FPU, 0, 3'b000, 1, 9, 0, 0, UNIT_MUL);
    drive(1, 9, UNIT_FDIV, 0, 3'b000, 1, 9, 1, 9, UNIT_FPU);
    drive(0, 0, UNIT_MUL, 9, 3'b001, 0, 0, 0, 0, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 1, 9, UNIT_FDIV);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 0, 0, UNIT_MUL);

    // x0 never busy on the integer file
    drive(1, 0, UNIT_MUL, 0, 3'b000, 1, 0, 0, 0, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 0, 3'b001, 1, 0, 0, 0, UNIT_MUL);

    // f0 trackable on the FP file
    sbf.issue_valid_id = 1'b1; sbf.issue_rd_id = 5'd0; sbf.issue_unit_id = UNIT_FPU;
    sbf.rd_used_id = 1'b1; sbf.rd_id = 5'd0;
    @(posedge clk);
    #1;
    sbf.issue_valid_id = 1'b0; sbf.rd_used_id = 1'b0; sbf.rs1_id = 5'd0; sbf.rs_used_id = 3'b001;
    @(negedge clk);
    check_val("fp_busy_vec_f0", sbf.busy_vec, 32'd1);
    check_val("fp_busy_rs1_f0", {31'd0, sbf.busy_rs1}, 32'd1);
    @(posedge clk);
    #1;
    sbf.rs_used_id = 3'b000;

    // error cases: writeback to idle x3, wrong tag on busy x4
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 1, 3, UNIT_MUL);
    drive(1, 4, UNIT_MUL, 0, 3'b000, 1, 4, 0, 0, UNIT_MUL);
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 1, 4, UNIT_DIV);
    repeat (2) drive(0, 0, UNIT_MUL, 4, 3'b001, 0, 0, 0, 0, UNIT_MUL);

    // random traffic over a small register window
    for (int n = 0; n < 80; n++) begin
      sbi.stall_id = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), unit_tag_t'(2'($urandom_range(0, 3))),
            $urandom_range(0, 6), 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            unit_tag_t'(2'($urandom_range(0, 3))));
    end
    sbi.stall_id = 1'b0;

    // long RAW stall, then asynchronous reset mid-stall
    do_reset();
    drive(1, 6, UNIT_MUL, 0, 3'b000, 1, 6, 0, 0, UNIT_MUL);
    repeat (20) drive(0, 0, UNIT_MUL, 6, 3'b001, 0, 0, 0, 0, UNIT_MUL);
`ifdef SCOREBOARD_PERF_CNT_EN
    check_val("raw_stall_cnt_sat", {28'd0, sbi.raw_stall_cnt}, 32'd15);
    check_val("waw_stall_cnt_idle", {28'd0, sbi.waw_stall_cnt}, 32'd0);
`endif
    reset_n = 1'b0;
    #1;
    check_val("async_busy_vec", sbi.busy_vec, 32'd0);
    check_val("async_fp_busy_vec", sbf.busy_vec, 32'd0);
    check_val("async_sb_err", {31'd0, sbi.sb_err}, 32'd0);
    check_val("async_raw_stall", {31'd0, sbi.raw_stall}, 32'd0);
`ifdef SCOREBOARD_PERF_CNT_EN
    check_val("async_raw_cnt", {28'd0, sbi.raw_stall_cnt}, 32'd0);
    check_val("async_waw_cnt", {28'd0, sbi.waw_stall_cnt}, 32'd0);
`endif
    #2;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // writeback of a pre-reset op is an error
    drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 1, 6, UNIT_MUL);
    repeat (2) drive(0, 0, UNIT_MUL, 0, 3'b000, 0, 0, 0, 0, UNIT_MUL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
